// File: rtl/fadd_rs_sched.sv
// Reservation station and single-issue scheduler feeding an external combinational fpADD_32.
// Build option: define FADD_RS_AGE_EN to issue the oldest ready entry instead of the lowest-index one.
module fadd_rs_sched #(
    parameter int NUM_RS   = 3,
    parameter int TAG_W    = 4,
    parameter int EXEC_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [TAG_W-1:0] disp_tag,
    input  logic [31:0]      disp_vj,
    input  logic [31:0]      disp_vk,
    input  logic [TAG_W-1:0] disp_qj,
    input  logic [TAG_W-1:0] disp_qk,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic [31:0]      fa_x1,
    output logic [31:0]      fa_x2,
    input  logic [31:0]      fa_x3,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic [31:0]      res_data,
    input  logic             res_grant,
    output logic [3:0]       busy_cnt
);
    localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, WAIT_CDB} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  sel;
    logic [NUM_RS-1:0] busy;
    logic [NUM_RS-1:0] issued;
    logic [TAG_W-1:0]  tag [NUM_RS];
    logic [TAG_W-1:0]  qj  [NUM_RS];
    logic [TAG_W-1:0]  qk  [NUM_RS];
    logic [31:0]       vj  [NUM_RS];
    logic [31:0]       vk  [NUM_RS];

    logic [NUM_RS-1:0] ready;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  pick;
    logic              dispatch;
    logic              cdb_live;
    logic              disp_hit_j;
    logic              disp_hit_k;

    assign dispatch   = disp_valid & disp_ready;
    assign cdb_live   = cdb_valid & (cdb_tag != '0);
    assign disp_hit_j = cdb_live & (disp_qj == cdb_tag);
    assign disp_hit_k = cdb_live & (disp_qk == cdb_tag);

    always_comb begin
        disp_ready = ~&busy;
        free_idx   = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        busy_cnt = '0;
        ready    = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            busy_cnt = busy_cnt + {3'b000, busy[i]};
            ready[i] = busy[i] & ~issued[i] & (qj[i] == '0) & (qk[i] == '0);
        end
    end

`ifdef FADD_RS_AGE_EN
    // older[i][j] is set when entry i was dispatched before entry j
    logic [NUM_RS-1:0] older [NUM_RS];

    always_comb begin
        logic oldest;
        oldest = 1'b0;
        pick   = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            oldest = ready[i];
            for (int j = 0; j < NUM_RS; j++) begin
                if (j != i && ready[j] && older[j][i]) oldest = 1'b0;
            end
            if (oldest) pick = IDX_W'(i);
        end
    end
`else
    always_comb begin
        pick = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (ready[i]) pick = IDX_W'(i);
        end
    end
`endif

    // Operand/tag storage: written on dispatch, updated by CDB snoop while waiting
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RS; i++) begin
            if (dispatch && free_idx == IDX_W'(i)) begin
                tag[i] <= disp_tag;
                vj[i]  <= disp_hit_j ? cdb_data : disp_vj;
                qj[i]  <= disp_hit_j ? '0 : disp_qj;
                vk[i]  <= disp_hit_k ? cdb_data : disp_vk;
                qk[i]  <= disp_hit_k ? '0 : disp_qk;
            end else if (busy[i] && cdb_live) begin
                if (qj[i] == cdb_tag) begin
                    vj[i] <= cdb_data;
                    qj[i] <= '0;
                end
                if (qk[i] == cdb_tag) begin
                    vk[i] <= cdb_data;
                    qk[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy      <= '0;
            issued    <= '0;
            state     <= IDLE;
            cnt       <= '0;
            sel       <= '0;
            res_valid <= 1'b0;
            res_tag   <= '0;
            res_data  <= '0;
            fa_x1     <= '0;
            fa_x2     <= '0;
`ifdef FADD_RS_AGE_EN
            for (int i = 0; i < NUM_RS; i++) older[i] <= '0;
`endif
        end else begin
            if (dispatch) begin
                busy[free_idx]   <= 1'b1;
                issued[free_idx] <= 1'b0;
`ifdef FADD_RS_AGE_EN
                for (int j = 0; j < NUM_RS; j++) begin
                    older[free_idx][j] <= 1'b0;
                    older[j][free_idx] <= busy[j];
                end
`endif
            end
            case (state)
                IDLE: begin
                    if (|ready) begin
                        issued[pick] <= 1'b1;
                        sel          <= pick;
                        fa_x1        <= vj[pick];
                        fa_x2        <= vk[pick];
                        cnt          <= 4'(EXEC_LAT - 1);
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        res_data  <= fa_x3;
                        res_tag   <= tag[sel];
                        res_valid <= 1'b1;
                        state     <= WAIT_CDB;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WAIT_CDB: begin
                    // Entry stays busy through the grant cycle, so dispatch cannot reuse it until after
                    if (res_grant) begin
                        busy[sel]   <= 1'b0;
                        issued[sel] <= 1'b0;
                        res_valid   <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fadd_rs_sched.sv
// Bench for fadd_rs_sched: transaction-level reservation-station model plus directed literal checks.
module tb_fadd_rs_sched;
    localparam int NUM_RS   = 3;
    localparam int EXEC_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [3:0]  disp_tag = '0;
    logic [31:0] disp_vj = '0;
    logic [31:0] disp_vk = '0;
    logic [3:0]  disp_qj = '0;
    logic [3:0]  disp_qk = '0;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic [31:0] fa_x1, fa_x2, fa_x3;
    logic        res_valid;
    logic [3:0]  res_tag;
    logic [31:0] res_data;
    logic        res_grant = 1'b0;
    logic [3:0]  busy_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fadd_rs_sched #(.NUM_RS(NUM_RS), .TAG_W(4), .EXEC_LAT(EXEC_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_tag(disp_tag),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj(disp_qj), .disp_qk(disp_qk),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .fa_x1(fa_x1), .fa_x2(fa_x2), .fa_x3(fa_x3),
        .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data), .res_grant(res_grant),
        .busy_cnt(busy_cnt)
    );

    // Single-precision helpers via double; denormals flush to zero, exact for the small values used here
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52];
        if (e == 11'd0) return 32'h0;
        return {d[63], 8'(e - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rnd_fp();
        return r2f(real'(int'($urandom_range(0, 256)) - 128) / 4.0);
    endfunction

    assign fa_x3 = fadd(fa_x1, fa_x2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          busy;
        bit          issued;
        logic [3:0]  tag;
        logic [3:0]  qj;
        logic [3:0]  qk;
        logic [31:0] vj;
        logic [31:0] vk;
        int unsigned age;
    } ent_t;

    ent_t        m [NUM_RS];
    int unsigned seq = 0;
    bit          op_on = 0;
    bit          res_on = 0;
    int          op_left = 0;
    int          op_idx = 0;
    logic [31:0] m_x1 = '0, m_x2 = '0, m_rdata = '0;
    logic [3:0]  m_rtag = '0;

    always @(posedge clk) begin : model
        int  pick;
        int  fr;
        bit  cdb_hit;
        if (!rst_n) begin
            for (int i = 0; i < NUM_RS; i++) begin
                m[i].busy = 0;
                m[i].issued = 0;
            end
            op_on = 0; res_on = 0;
            m_x1 = '0; m_x2 = '0; m_rdata = '0; m_rtag = '0;
        end else begin
            pick = -1;
            fr = -1;
            for (int i = 0; i < NUM_RS; i++) begin
                if (m[i].busy && !m[i].issued && m[i].qj == 0 && m[i].qk == 0) begin
`ifdef FADD_RS_AGE_EN
                    if (pick < 0 || m[i].age < m[pick].age) pick = i;
`else
                    if (pick < 0) pick = i;
`endif
                end
                if (!m[i].busy && fr < 0) fr = i;
            end
            cdb_hit = cdb_valid && cdb_tag != 0;
            if (cdb_hit) begin
                for (int i = 0; i < NUM_RS; i++) begin
                    if (m[i].busy && m[i].qj == cdb_tag) begin m[i].vj = cdb_data; m[i].qj = 0; end
                    if (m[i].busy && m[i].qk == cdb_tag) begin m[i].vk = cdb_data; m[i].qk = 0; end
                end
            end
            if (op_on && !res_on) begin
                op_left--;
                if (op_left == 0) begin
                    res_on = 1;
                    m_rdata = fadd(m_x1, m_x2);
                    m_rtag = m[op_idx].tag;
                end
            end else if (res_on && res_grant) begin
                m[op_idx].busy = 0;
                m[op_idx].issued = 0;
                op_on = 0; res_on = 0;
            end else if (!op_on && pick >= 0) begin
                op_on = 1; op_idx = pick; op_left = EXEC_LAT;
                m_x1 = m[pick].vj; m_x2 = m[pick].vk;
                m[pick].issued = 1;
            end
            if (disp_valid && fr >= 0) begin
                m[fr].busy = 1; m[fr].issued = 0; m[fr].tag = disp_tag;
                m[fr].age = seq; seq++;
                if (cdb_hit && disp_qj == cdb_tag) begin m[fr].vj = cdb_data; m[fr].qj = 0; end
                else begin m[fr].vj = disp_vj; m[fr].qj = disp_qj; end
                if (cdb_hit && disp_qk == cdb_tag) begin m[fr].vk = cdb_data; m[fr].qk = 0; end
                else begin m[fr].vk = disp_vk; m[fr].qk = disp_qk; end
            end
        end
    end

    always @(negedge clk) begin : compare
        int cnt;
        bit anyfree;
        cnt = 0;
        anyfree = 0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (m[i].busy) cnt++;
            else anyfree = 1;
        end
        chk("disp_ready", 32'(disp_ready), 32'(anyfree));
        chk("busy_cnt", 32'(busy_cnt), 32'(cnt));
        chk("res_valid", 32'(res_valid), 32'(res_on));
        chk("res_tag", 32'(res_tag), 32'(m_rtag));
        chk("res_data", res_data, m_rdata);
        chk("fa_x1", fa_x1, m_x1);
        chk("fa_x2", fa_x2, m_x2);
    end

    // ---------------- stimulus helpers ----------------
    task automatic disp(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] j, input logic [3:0] k);
        disp_valid = 1; disp_tag = t; disp_vj = a; disp_vk = b; disp_qj = j; disp_qk = k;
        @(negedge clk);
        disp_valid = 0;
    endtask

    task automatic bcast(input logic [3:0] t, input logic [31:0] d);
        cdb_valid = 1; cdb_tag = t; cdb_data = d;
        @(negedge clk);
        cdb_valid = 0;
    endtask

    task automatic wait_res(input string name);
        for (int k = 0; k < 12 && !res_valid; k++) @(negedge clk);
        chk(name, 32'(res_valid), 32'd1);
    endtask

    task automatic grant();
        res_grant = 1;
        @(negedge clk);
        res_grant = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(disp_ready), 32'd1);
        chk("rst_cnt", 32'(busy_cnt), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", res_data, 32'h0);
        chk("rst_x1", fa_x1, 32'h0);
        rst_n = 1;

        // 4.5 + 0.5: result three edges after dispatch
        disp(4'd1, 32'h40900000, 32'h3F000000, 4'd0, 4'd0);
        chk("t1_busy", 32'(busy_cnt), 32'd1);
        @(negedge clk);
        chk("t1_x1", fa_x1, 32'h40900000);
        chk("t1_early1", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("t1_early2", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid", 32'(res_valid), 32'd1);
        chk("t1_data", res_data, 32'h40A00000);
        chk("t1_tag", 32'(res_tag), 32'd1);
        grant();
        chk("t1_freed", 32'(busy_cnt), 32'd0);
        chk("t1_novalid", 32'(res_valid), 32'd0);

        // operand arrives over CDB: 4.0 + -0.25
        disp(4'd2, 32'h0, 32'hBE800000, 4'd5, 4'd0);
        bcast(4'd5, 32'h40800000);
        @(negedge clk);
        chk("t2_issue", fa_x1, 32'h40800000);
        wait_res("t2_wait");
        chk("t2_data", res_data, 32'h40700000);
        chk("t2_tag", 32'(res_tag), 32'd2);
        grant();

        // fill all entries, all waiting on tag 9
        disp(4'd3, 32'h0, 32'h40000000, 4'd9, 4'd0);
        disp(4'd4, 32'h0, 32'h40400000, 4'd9, 4'd0);
        disp(4'd5, 32'h0, 32'h40800000, 4'd9, 4'd0);
        chk("t3_full_cnt", 32'(busy_cnt), 32'd3);
        chk("t3_full_rdy", 32'(disp_ready), 32'd0);
        disp(4'd6, 32'h3F800000, 32'h3F800000, 4'd0, 4'd0);
        chk("t3_ignored", 32'(busy_cnt), 32'd3);
        bcast(4'd9, 32'h3F800000);
        wait_res("t3_wait");
        chk("t3_tag", 32'(res_tag), 32'd3);
        chk("t3_data", res_data, 32'h40400000);
        disp_valid = 1; disp_tag = 4'd6; disp_vj = 32'h3F800000; disp_vk = 32'h3F800000;
        disp_qj = 0; disp_qk = 0;
        res_grant = 1;
        @(negedge clk);
        res_grant = 0; disp_valid = 0;
        chk("t3_rdy_after", 32'(disp_ready), 32'd1);
        chk("t3_cnt_after", 32'(busy_cnt), 32'd2);

        // held grant: result stays, nothing else issues
        @(negedge clk);
        chk("t4_next_issue", fa_x2, 32'h40400000);
        wait_res("t4_wait");
        for (int c = 0; c < 10; c++) begin
            chk("t4_hold_valid", 32'(res_valid), 32'd1);
            chk("t4_hold_tag", 32'(res_tag), 32'd4);
            chk("t4_hold_data", res_data, 32'h40800000);
            chk("t4_hold_x2", fa_x2, 32'h40400000);
            @(negedge clk);
        end
        grant();
        @(negedge clk);
        chk("t4_after_grant", fa_x2, 32'h40800000);
        wait_res("t4_wait2");
        chk("t4_tag2", 32'(res_tag), 32'd5);
        chk("t4_data2", res_data, 32'h40A00000);
        grant();

        // dispatch coinciding with the producing broadcast
        disp_valid = 1; disp_tag = 4'd8; disp_vj = 32'h0; disp_vk = 32'h40000000;
        disp_qj = 4'd7; disp_qk = 4'd0;
        cdb_valid = 1; cdb_tag = 4'd7; cdb_data = 32'h3F800000;
        @(negedge clk);
        disp_valid = 0; cdb_valid = 0;
        @(negedge clk);
        chk("t5_issue", fa_x1, 32'h3F800000);
        wait_res("t5_wait");
        chk("t5_data", res_data, 32'h40400000);
        chk("t5_tag", 32'(res_tag), 32'd8);
        grant();

        // reset mid-execution
        disp(4'd1, 32'h3F800000, 32'h3F800000, 4'd0, 4'd0);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk("t6_valid", 32'(res_valid), 32'd0);
        chk("t6_cnt", 32'(busy_cnt), 32'd0);
        chk("t6_rdy", 32'(disp_ready), 32'd1);
        chk("t6_x1", fa_x1, 32'h0);
        rst_n = 1;
        disp(4'd1, 32'h3F800000, 32'h3F800000, 4'd0, 4'd0);
        disp(4'd2, 32'h3F800000, 32'h40000000, 4'd0, 4'd0);
        disp(4'd3, 32'h0, 32'h40800000, 4'd12, 4'd0);
        wait_res("t6_w1");
        chk("t6_tag1", 32'(res_tag), 32'd1);
        grant();
        wait_res("t6_w2");
        chk("t6_tag2", 32'(res_tag), 32'd2);
        chk("t6_data2", res_data, 32'h40400000);
        grant();
        disp(4'd4, 32'h0, 32'h40000000, 4'd12, 4'd0);
        chk("t6_two", 32'(busy_cnt), 32'd2);
        bcast(4'd12, 32'h3F800000);
        wait_res("t6_w3");
`ifdef FADD_RS_AGE_EN
        chk("t6_first_tag", 32'(res_tag), 32'd3);
        chk("t6_first_data", res_data, 32'h40A00000);
`else
        chk("t6_first_tag", 32'(res_tag), 32'd4);
        chk("t6_first_data", res_data, 32'h40400000);
`endif
        grant();
        wait_res("t6_w4");
`ifdef FADD_RS_AGE_EN
        chk("t6_second_tag", 32'(res_tag), 32'd4);
`else
        chk("t6_second_tag", 32'(res_tag), 32'd3);
`endif
        grant();

        // randomized traffic, including occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            disp_valid = 1'($urandom_range(0, 1));
            disp_tag   = 4'($urandom_range(1, 15));
            disp_vj    = rnd_fp();
            disp_vk    = rnd_fp();
            disp_qj    = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 6));
            disp_qk    = ($urandom_range(0, 2) != 0) ? 4'd0 : 4'($urandom_range(1, 6));
            cdb_valid  = ($urandom_range(0, 9) < 4);
            cdb_tag    = 4'($urandom_range(0, 6));
            cdb_data   = rnd_fp();
            res_grant  = ($urandom_range(0, 9) < 6);
            @(negedge clk);
        end
        rst_n = 1; disp_valid = 0; cdb_valid = 0; res_grant = 0;
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
